chess_clock_ctrl: RTL
=====================

Name: chess_clock_ctrl

Overview:
Two-player chess-clock sequencer for the DE10 soc_system fabric. It owns both players' countdown timers, the run/pause/flag state machine, per-move increment and move counting. Its registered outputs drive pio_external_clock_time_export and pio_external_clock_mode_export so the HPS can read clock status. Button inputs arrive already debounced as single-cycle pulses.

Parameters:
CLK_HZ, 50000000, frequency of clk_clk in Hz
TICK_HZ, 10, timer resolution in ticks per second (10 gives tenths of a second)
TIME_W, 16, width of each player's time register in ticks

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  reset, synchronous, active-low
start_i  in  1  pulse; start game from IDLE, or resume from PAUSED
pause_i  in  1  pulse; pause when running, resume when PAUSED
new_game_i  in  1  pulse; abort and return to IDLE with reloaded times
btn_a_i  in  1  pulse; player A ends move
btn_b_i  in  1  pulse; player B ends move
cfg_base_i  in  TIME_W  starting time per player, in ticks
cfg_inc_i  in  8  per-move increment, in ticks
time_export_o  out  32  {time_b[15:0], time_a[15:0]}
mode_export_o  out  32  status word (bit map below)
tick_o  out  1  prescaler strobe, one cycle wide

Behaviour:
- Reset values: state IDLE; time_a = time_b = 0; inc_q = 0; move_cnt = 0; flags = 0; prescaler = 0; tick_o = 0.
- All outputs are registered and reflect an event 1 cycle after it.
- Prescaler:
  - DIV = CLK_HZ/TICK_HZ; counts 0..DIV-1; tick fires when count = DIV-1, then the count wraps to 0.
  - Counts only in RUN_A and RUN_B; holds its value in PAUSED.
  - Cleared on any player switch, on entering IDLE and on entering FLAG.
  - With a cleared counter, the first decrement happens exactly DIV cycles after entering a run state.
- State codes: IDLE=0, RUN_A=1, RUN_B=2, PAUSED=3, FLAG=4.
- Priority, highest first: new_game_i > pause_i/start_i > button > tick.
- IDLE:
  - start_i with cfg_base_i != 0: load time_a = time_b = cfg_base_i, latch inc_q = cfg_inc_i, clear move_cnt, go to RUN_A.
  - start_i with cfg_base_i = 0: no action.
  - Buttons are ignored.
- RUN_A (RUN_B is symmetric):
  - Tick decrements time_a.
  - If a tick occurs while time_a = 1: time_a becomes 0, flag_a is set, go to FLAG.
  - btn_a_i: time_a = min(time_a + inc_q, 2^TIME_W - 1), move_cnt++ (wraps at 16 bits), go to RUN_B.
  - btn_b_i is ignored.
  - pause_i: go to PAUSED and record resume player A.
- Tick and own button in the same cycle:
  - Decrement first, then add the increment.
  - If the decrement reaches 0, FLAG wins: the button is ignored and move_cnt is unchanged.
- PAUSED: start_i or pause_i resumes to the recorded player with the prescaler value intact. Buttons are ignored; times are frozen.
- FLAG: everything is frozen; only new_game_i exits.
- new_game_i in any state: go to IDLE, time_a = time_b = cfg_base_i, flags and move_cnt cleared, inc_q = cfg_inc_i.
- Reset asserted mid-game: all state returns to the reset values on the next edge; no partial update.
- mode_export_o bit map:
  - [2:0] state code
  - [3] active/resume player (0 = A, 1 = B); 0 in IDLE
  - [4] flag_a
  - [5] flag_b
  - [7:6] zero
  - [15:8] inc_q
  - [31:16] move_cnt
- Width rules: time_a and time_b are zero-extended into 16-bit export fields when TIME_W < 16; TIME_W > 16 is unsupported.

Decomposition:
- chess_clock_pkg holds:
  - the state enum and its encodings
  - the mode_export bit-position constants
  - the export field offsets
- One sub-module: chess_tick_gen (prescaler with enable, clear and DIV parameter; outputs tick). All other logic stays in chess_clock_ctrl.

Test Plan:
All scenarios use CLK_HZ=100 and TICK_HZ=10, so DIV=10.
1. Reset, then start_i with cfg_base=5, inc=2 -> state 1; time_a=4 after 10 cycles; time_a=0 after 50 cycles with state 4, flag_a=1, time_b=5, mode[31:16]=0.
2. Same start, btn_a_i after 3 ticks -> time_a=2+2=4, state 2, move_cnt=1; first time_b decrement (to 4) exactly 10 cycles after the press.
3. pause_i at prescaler count 5, idle 100 cycles, then start_i -> no time change while paused; next decrement 5 cycles after resume; mode[3] preserved.
4. btn_a_i on a tick cycle -> with time_a=1: FLAG, flag_a=1, move_cnt unchanged; with time_a=3: time_a=4, state 2.
5. time_a=0xFFFE, inc=5, btn_a_i -> time_a saturates at 0xFFFF.
6. new_game_i while in FLAG with cfg_base=7 -> state 0, time_export=0x00070007, mode[5:4]=0, move_cnt=0; start_i with cfg_base=0 -> stays in IDLE.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// rtl/chess_clock_pkg.sv - state encodings and export field layout for chess_clock_ctrl
package chess_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_A  = 3'd1,
    ST_RUN_B  = 3'd2,
    ST_PAUSED = 3'd3,
    ST_FLAG   = 3'd4
  } state_e;

  localparam int MODE_STATE_LSB  = 0;
  localparam int MODE_STATE_W    = 3;
  localparam int MODE_PLAYER_BIT = 3;
  localparam int MODE_FLAG_A_BIT = 4;
  localparam int MODE_FLAG_B_BIT = 5;
  localparam int MODE_INC_LSB    = 8;
  localparam int MODE_MOVE_LSB   = 16;

  localparam int EXPORT_TIME_A_LSB = 0;
  localparam int EXPORT_TIME_B_LSB = 16;
  localparam int EXPORT_TIME_W     = 16;

  function automatic logic is_running(input state_e s);
    return (s == ST_RUN_A) || (s == ST_RUN_B);
  endfunction

endpackage

// File: rtl/chess_tick_gen.sv
// rtl/chess_tick_gen.sv - prescaler producing a one-cycle tick every DIV enabled cycles
module chess_tick_gen #(
  parameter int DIV = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chess_clock_ctrl.sv
// rtl/chess_clock_ctrl.sv - two-player chess clock: timers, run/pause/flag FSM, increment, move count
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 10,
  parameter int TIME_W  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              new_game_i,
  input  logic              btn_a_i,
  input  logic              btn_b_i,
  input  logic [TIME_W-1:0] cfg_base_i,
  input  logic [7:0]        cfg_inc_i,
  output logic [31:0]       time_export_o,
  output logic [31:0]       mode_export_o,
  output logic              tick_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_a_q, time_a_d;
  logic [TIME_W-1:0] time_b_q, time_b_d;
  logic [7:0]        inc_q, inc_d;
  logic [15:0]       move_cnt_q, move_cnt_d;
  logic              flag_a_q, flag_a_d;
  logic              flag_b_q, flag_b_d;
  logic              player_q, player_d;
  logic              tick_q;

  logic              tick;
  logic              tick_en;
  logic              tick_clr;
  logic [TIME_W-1:0] run_time;

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] t,
                                                input logic [7:0]        inc);
    logic [TIME_W:0] sum;
    sum = {1'b0, t} + (TIME_W + 1)'(inc);
    return sum[TIME_W] ? {TIME_W{1'b1}} : sum[TIME_W-1:0];
  endfunction

  // A pause or abort in the same cycle must not let the prescaler advance.
  assign tick_en = is_running(state_q) && !pause_i && !new_game_i;

  chess_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk_clk),
    .resetn (reset_reset_n),
    .en     (tick_en),
    .clr    (tick_clr),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    time_a_d   = time_a_q;
    time_b_d   = time_b_q;
    inc_d      = inc_q;
    move_cnt_d = move_cnt_q;
    flag_a_d   = flag_a_q;
    flag_b_d   = flag_b_q;
    player_d   = player_q;
    tick_clr   = 1'b0;
    run_time   = '0;

    if (new_game_i) begin
      state_d    = ST_IDLE;
      time_a_d   = cfg_base_i;
      time_b_d   = cfg_base_i;
      inc_d      = cfg_inc_i;
      move_cnt_d = '0;
      flag_a_d   = 1'b0;
      flag_b_d   = 1'b0;
      player_d   = 1'b0;
      tick_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_clr = 1'b1;
          if (start_i && (cfg_base_i != '0)) begin
            state_d    = ST_RUN_A;
            time_a_d   = cfg_base_i;
            time_b_d   = cfg_base_i;
            inc_d      = cfg_inc_i;
            move_cnt_d = '0;
            player_d   = 1'b0;
          end
        end

        ST_RUN_A: begin
          if (pause_i) begin
            state_d  = ST_PAUSED;
            player_d = 1'b0;
          end else if (tick && (time_a_q == TIME_W'(1))) begin
            time_a_d = '0;
            flag_a_d = 1'b1;
            state_d  = ST_FLAG;
            tick_clr = 1'b1;
          end else begin
            // Decrement happens before the increment is credited.
            run_time = tick ? time_a_q - 1'b1 : time_a_q;
            time_a_d = run_time;
            if (btn_a_i) begin
              time_a_d   = sat_add(run_time, inc_q);
              move_cnt_d = move_cnt_q + 16'd1;
              state_d    = ST_RUN_B;
              player_d   = 1'b1;
              tick_clr   = 1'b1;
            end
          end
        end

        ST_RUN_B: begin
          if (pause_i) begin
            state_d  = ST_PAUSED;
            player_d = 1'b1;
          end else if (tick && (time_b_q == TIME_W'(1))) begin
            time_b_d = '0;
            flag_b_d = 1'b1;
            state_d  = ST_FLAG;
            tick_clr = 1'b1;
          end else begin
            run_time = tick ? time_b_q - 1'b1 : time_b_q;
            time_b_d = run_time;
            if (btn_b_i) begin
              time_b_d   = sat_add(run_time, inc_q);
              move_cnt_d = move_cnt_q + 16'd1;
              state_d    = ST_RUN_A;
              player_d   = 1'b0;
              tick_clr   = 1'b1;
            end
          end
        end

        ST_PAUSED: begin
          if (start_i || pause_i) begin
            state_d = player_q ? ST_RUN_B : ST_RUN_A;
          end
        end

        ST_FLAG: begin
          tick_clr = 1'b1;
        end

        default: begin
          state_d  = ST_IDLE;
          tick_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      time_a_q   <= '0;
      time_b_q   <= '0;
      inc_q      <= '0;
      move_cnt_q <= '0;
      flag_a_q   <= 1'b0;
      flag_b_q   <= 1'b0;
      player_q   <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_a_q   <= time_a_d;
      time_b_q   <= time_b_d;
      inc_q      <= inc_d;
      move_cnt_q <= move_cnt_d;
      flag_a_q   <= flag_a_d;
      flag_b_q   <= flag_b_d;
      player_q   <= player_d;
      tick_q     <= tick;
    end
  end

  // Outputs are pure wiring of flops so the HPS sees a stable registered view.
  always_comb begin
    time_export_o = '0;
    time_export_o[EXPORT_TIME_A_LSB +: EXPORT_TIME_W] = EXPORT_TIME_W'(time_a_q);
    time_export_o[EXPORT_TIME_B_LSB +: EXPORT_TIME_W] = EXPORT_TIME_W'(time_b_q);

    mode_export_o = '0;
    mode_export_o[MODE_STATE_LSB +: MODE_STATE_W] = state_q;
    mode_export_o[MODE_PLAYER_BIT]                = player_q;
    mode_export_o[MODE_FLAG_A_BIT]                = flag_a_q;
    mode_export_o[MODE_FLAG_B_BIT]                = flag_b_q;
    mode_export_o[MODE_INC_LSB +: 8]              = inc_q;
    mode_export_o[MODE_MOVE_LSB +: 16]            = move_cnt_q;
  end

  assign tick_o = tick_q;

endmodule
